// File: rtl/div_unit.sv
// div_unit: sequential restoring HI/LO divider (DIV/DIVU) with MFHI/MFLO read port.
// Remainder goes to HI and quotient to LO after a fixed 33-edge latency.
module div_unit #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] OP_DIV  = 4'b0110,
  parameter logic [3:0] OP_DIVU = 4'b0111,
  parameter logic [3:0] OP_MFHI = 4'b0100,
  parameter logic [3:0] OP_MFLO = 4'b0101
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       divwe,
  output logic [WIDTH-1:0] rdata,
  output logic             muxdiv,
  output logic             busy,
  output logic             done,
  output logic             stall
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_hi, r_lo, r_rdata, r_rem, r_quo, r_bmag, r_a;
  logic [CW-1:0]    r_cnt;
  logic             r_qneg, r_rneg, r_dz, r_busy, r_done;
  logic             w_sgn, w_start, w_rd;
  logic [WIDTH-1:0] w_amag, w_bmag;
  logic [WIDTH:0]   w_trial;
  assign w_sgn   = divwe == OP_DIV;
  assign w_start = w_sgn || divwe == OP_DIVU;
  assign w_rd    = divwe == OP_MFHI || divwe == OP_MFLO;
  assign w_amag  = (w_sgn && a[WIDTH-1]) ? -a : a;
  assign w_bmag  = (w_sgn && b[WIDTH-1]) ? -b : b;
  // Shifted partial remainder needs one extra bit so the trial subtract cannot wrap.
  assign w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_bmag};
  assign muxdiv  = !w_rd;
  assign stall   = r_busy && (w_start || w_rd);
  assign rdata   = r_rdata;
  assign busy    = r_busy;
  assign done    = r_done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_rdata <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_bmag  <= '0;
      r_a     <= '0;
      r_cnt   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_start) begin
            r_rem   <= '0;
            r_quo   <= w_amag;
            r_bmag  <= w_bmag;
            r_a     <= a;
            r_qneg  <= w_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_rneg  <= w_sgn && a[WIDTH-1];
            r_dz    <= b == '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end else if (w_rd) begin
            r_rdata <= divwe == OP_MFHI ? r_hi : r_lo;
          end
        end
        CALC: begin
          r_rem   <= w_trial[WIDTH] ? {r_rem[WIDTH-2:0], r_quo[WIDTH-1]} : w_trial[WIDTH-1:0];
          r_quo   <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
          r_cnt   <= r_cnt + 1'b1;
          r_state <= r_cnt == CW'(WIDTH - 1) ? FIX : CALC;
        end
        FIX: begin
          r_lo    <= r_dz ? '1 : (r_qneg ? -r_quo : r_quo);
          r_hi    <= r_dz ? r_a : (r_rneg ? -r_rem : r_rem);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven divide vectors plus directed stall, reset-abort and no-op sequences.
module tb_div_unit;
  localparam logic [3:0] DIV = 4'b0110, DIVU = 4'b0111, MFHI = 4'b0100, MFLO = 4'b0101, NOP = 4'b0000;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] a = '0, b = '0, rdata;
  logic [3:0]  divwe = NOP;
  logic        muxdiv, busy, done, stall;
  int          compared = 0, mismatched = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, lo, hi;
  } vec_t;
  vec_t tbl[8];

  div_unit dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .divwe(divwe),
    .rdata(rdata), .muxdiv(muxdiv), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read(input logic [3:0] op, input logic [31:0] exp, input string name);
    divwe = op;
    #1;
    chk({name, "_muxdiv"}, 32'(muxdiv), 32'd0);
    step();
    chk(name, rdata, exp);
    divwe = NOP;
  endtask

  // Issue a divide and wait for done; returns the number of edges after acceptance.
  task automatic run_div(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, output int n);
    divwe = op; a = x; b = y;
    step();
    divwe = NOP;
    chk("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (n < 100) begin
      step();
      n++;
      if (done) break;
    end
    if (n >= 100) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    logic seen_done;
    tbl[0] = '{DIVU, 32'd100,        32'd7,        32'd14,       32'd2};
    tbl[1] = '{DIV,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF};
    tbl[2] = '{DIVU, 32'hFFFF_FFF9,  32'd2,        32'h7FFF_FFFC, 32'd1};
    tbl[3] = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    tbl[4] = '{DIVU, 32'h0000_1234,  32'd0,        32'hFFFF_FFFF, 32'h0000_1234};
    tbl[5] = '{DIV,  32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFB};
    tbl[6] = '{DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
    tbl[7] = '{DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF};

    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    step();
    read(MFHI, 32'd0, "reset_hi");
    read(MFLO, 32'd0, "reset_lo");

    for (int i = 0; i < 8; i++) begin
      run_div(tbl[i].op, tbl[i].a, tbl[i].b, n);
      chk($sformatf("v%0d_latency", i), 32'(n), 32'd33);
      chk($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
      read(MFLO, tbl[i].lo, $sformatf("v%0d_lo", i));
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      read(MFHI, tbl[i].hi, $sformatf("v%0d_hi", i));
    end

    // Stalled read and ignored divide during busy; the read held through E33 lands at E34.
    divwe = DIVU; a = 32'd100; b = 32'd7;
    step();
    divwe = NOP;
    repeat (4) step();
    divwe = MFLO;
    #1;
    chk("stall_read", 32'(stall), 32'd1);
    step();
    chk("stall_rdata_hold", rdata, tbl[7].hi);
    divwe = DIVU; a = 32'd9; b = 32'd3;
    #1;
    chk("stall_div", 32'(stall), 32'd1);
    step();
    divwe = MFLO;
    n = 6;
    while (n < 60) begin
      #1;
      chk("stall_hold", 32'(stall), 32'd1);
      step();
      n++;
      if (done) break;
    end
    chk("stall_done_edge", 32'(n), 32'd33);
    chk("fix_read_stalled", rdata, tbl[7].hi);
    #1;
    chk("stall_released", 32'(stall), 32'd0);
    step();
    chk("read_after_fix", rdata, 32'd14);
    divwe = NOP;
    step();
    chk("second_div_dropped", 32'(busy), 32'd0);
    read(MFHI, 32'd2, "stall_hi");

    // Reset mid-divide aborts and clears HI/LO.
    divwe = DIVU; a = 32'd100; b = 32'd7;
    step();
    divwe = NOP;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    step();
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      step();
      seen_done |= done;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    read(MFHI, 32'd0, "abort_hi");
    read(MFLO, 32'd0, "abort_lo");

    // Multiplier op code is a no-op for this unit.
    run_div(DIVU, 32'd100, 32'd7, n);
    step();
    divwe = 4'b0011; a = 32'hDEAD_BEEF; b = 32'd5;
    #1;
    chk("nop_muxdiv", 32'(muxdiv), 32'd1);
    chk("nop_stall", 32'(stall), 32'd0);
    repeat (3) step();
    chk("nop_busy", 32'(busy), 32'd0);
    divwe = NOP;
    read(MFLO, 32'd14, "nop_lo");
    read(MFHI, 32'd2, "nop_hi");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
